rgb_to_ycbcr: RTL and testbench

- Pipelined colour-space converter: 8-bit RGB pixels to 8-bit JPEG (full-range BT.601) Y, Cb, Cr.
- Sits at the front of the JPEG encoder. It feeds the per-component hw_jpegenc block-buffer/DCT chains.
- Accepts one pixel per clock. Fixed 3-cycle latency. No back-pressure.

---
 rtl/rgb_to_ycbcr_pkg.sv | 50 +++++
 rtl/rgb_to_ycbcr_mac3.sv | 78 +++++++
 rtl/rgb_to_ycbcr.sv | 114 +++++++++++
 tb/tb_rgb_to_ycbcr.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_to_ycbcr_pkg.sv
// ---------------------------------------------------------------------------
// rgb_to_ycbcr_pkg
// Shared constants and helpers for the RGB -> YCbCr (full-range BT.601, JPEG)
// colour-space converter.
//   - widths: PIX_W (pixel), PROD_W (unsigned product), SUM_W (signed sum)
//   - COEF:   3x3 signed coefficient table, row = Y/Cb/Cr, column = R/G/B,
//             scaled by 2^FRAC_BITS
//   - ROUND:  rounding term added before the shift
//   - OFS:    post-shift offset per component (0 for Y, CHROMA_OFS for Cb/Cr)
//   - clamp_u8(): saturate a signed sum to 0..255
// ---------------------------------------------------------------------------
package rgb_to_ycbcr_pkg;

    // Pipeline depth in clocks; the implementation is fixed at 3.
    localparam int LATENCY   = 3;
    localparam int FRAC_BITS = 8;
    localparam int PIX_W     = 8;
    localparam int PROD_W    = 16;
    localparam int SUM_W     = 18;
    localparam int COEF_W    = 9;
    localparam int NCOMP     = 3;

    localparam logic signed [SUM_W-1:0] ROUND      = 18'sd128;
    localparam logic signed [SUM_W-1:0] CHROMA_OFS = 18'sd128;

    // Rows: Y, Cb, Cr.  Columns: R, G, B.
    localparam logic signed [COEF_W-1:0] COEF [NCOMP][3] = '{
        '{ 9'sd77,   9'sd150,  9'sd29  },
        '{-9'sd43,  -9'sd85,   9'sd128 },
        '{ 9'sd128, -9'sd107, -9'sd21  }
    };

    localparam logic signed [SUM_W-1:0] OFS [NCOMP] = '{18'sd0, CHROMA_OFS, CHROMA_OFS};

    localparam logic signed [SUM_W-1:0] U8_MAX = 18'sd255;

    // Saturate a signed value to the unsigned 8-bit range.
    function automatic logic [PIX_W-1:0] clamp_u8(input logic signed [SUM_W-1:0] v);
        logic [PIX_W-1:0] res;
        if (v[SUM_W-1]) begin
            res = '0;
        end else if (v > U8_MAX) begin
            res = '1;
        end else begin
            res = v[PIX_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/rgb_to_ycbcr_mac3.sv
// ---------------------------------------------------------------------------
// ycc_mac3
// Registered three-product weighted sum for one colour component:
//   stage 1: register |coef_i| * pix_i (16-bit unsigned) plus the coef sign
//   stage 2: register sum = sum_i(+/- product_i) + ROUND (18-bit signed)
// Ports:
//   clock, reset        - clock, synchronous active-high reset
//   coef0..coef2        - signed coefficients (expected static)
//   pix0..pix2          - unsigned 8-bit pixel components
//   sum                 - registered signed weighted sum, 2 clocks after input
// ---------------------------------------------------------------------------
module ycc_mac3
    import rgb_to_ycbcr_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic signed [COEF_W-1:0] coef0,
    input  logic signed [COEF_W-1:0] coef1,
    input  logic signed [COEF_W-1:0] coef2,
    input  logic [PIX_W-1:0]         pix0,
    input  logic [PIX_W-1:0]         pix1,
    input  logic [PIX_W-1:0]         pix2,
    output logic signed [SUM_W-1:0]  sum
);

    logic signed [COEF_W-1:0] coef [3];
    logic [PIX_W-1:0]         pix  [3];
    logic signed [SUM_W-1:0]  term [3];
    logic signed [SUM_W-1:0]  sum_reg;
    logic signed [SUM_W-1:0]  sum_next;

    assign coef[0] = coef0;
    assign coef[1] = coef1;
    assign coef[2] = coef2;
    assign pix[0]  = pix0;
    assign pix[1]  = pix1;
    assign pix[2]  = pix2;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_tap
            logic [PIX_W-1:0]  mag;
            logic [PROD_W-1:0] prod_reg;
            logic              neg_reg;

            // Multiply by the magnitude so the product stays an unsigned
            // 8x8 multiply; the sign is re-applied in the adder stage.
            // |-128| = 128 still fits in 8 bits.
            assign mag = coef[gi][COEF_W-1] ? PIX_W'(-coef[gi]) : PIX_W'(coef[gi]);

            always_ff @(posedge clock) begin
                if (reset) begin
                    prod_reg <= '0;
                    neg_reg  <= 1'b0;
                end else begin
                    prod_reg <= PROD_W'(mag) * PROD_W'(pix[gi]);
                    neg_reg  <= coef[gi][COEF_W-1];
                end
            end

            assign term[gi] = neg_reg ? -$signed(SUM_W'(prod_reg))
                                      :  $signed(SUM_W'(prod_reg));
        end
    endgenerate

    assign sum_next = term[0] + term[1] + term[2] + ROUND;

    always_ff @(posedge clock) begin
        if (reset) begin
            sum_reg <= '0;
        end else begin
            sum_reg <= sum_next;
        end
    end

    assign sum = sum_reg;

endmodule

// File: rtl/rgb_to_ycbcr.sv
// ---------------------------------------------------------------------------
// rgb_to_ycbcr
// Pipelined RGB -> YCbCr (JPEG full-range BT.601) converter, one pixel per
// clock, fixed 3-clock latency, no back-pressure.
//   stages 1-2: one ycc_mac3 per component (products, then rounded sum)
//   stage 3:    floor shift by FRAC_BITS, chroma offset, clamp to 0..255
// Ports:
//   clock, reset   - clock, synchronous active-high reset
//   in_valid       - r/g/b carry a pixel this cycle
//   r, g, b        - 8-bit unsigned colour components
//   out_valid      - in_valid delayed by 3 clocks
//   out            - {Y, Cb, Cr}, 8 bits each
//   pix_cnt        - (YCC_PIX_CNT_EN only) 12-bit count of output beats, wraps
//   blk_done       - (YCC_PIX_CNT_EN only) pulse on every 64th output beat
// Build option: define YCC_PIX_CNT_EN to add pix_cnt / blk_done.
// ---------------------------------------------------------------------------
module rgb_to_ycbcr
    import rgb_to_ycbcr_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [PIX_W-1:0]         r,
    input  logic [PIX_W-1:0]         g,
    input  logic [PIX_W-1:0]         b,
    output logic                     out_valid,
    output logic [3*PIX_W-1:0]       out
`ifdef YCC_PIX_CNT_EN
    ,
    output logic [11:0]              pix_cnt,
    output logic                     blk_done
`endif
);

    logic valid_s1_reg;
    logic valid_s2_reg;
    logic out_valid_reg;

    logic signed [SUM_W-1:0] comp_sum [NCOMP];

    genvar gi;
    generate
        for (gi = 0; gi < NCOMP; gi++) begin : g_comp
            logic signed [SUM_W-1:0] scaled;
            logic [PIX_W-1:0]        comp_reg;

            ycc_mac3 u_mac (
                .clock (clock),
                .reset (reset),
                .coef0 (COEF[gi][0]),
                .coef1 (COEF[gi][1]),
                .coef2 (COEF[gi][2]),
                .pix0  (r),
                .pix1  (g),
                .pix2  (b),
                .sum   (comp_sum[gi])
            );

            // >>> on a signed value floors, so negative sums round toward
            // minus infinity; the +ROUND already added makes it round-half-up.
            assign scaled = (comp_sum[gi] >>> FRAC_BITS) + OFS[gi];

            always_ff @(posedge clock) begin
                if (reset) begin
                    comp_reg <= '0;
                end else begin
                    comp_reg <= clamp_u8(scaled);
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_s1_reg  <= 1'b0;
            valid_s2_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            valid_s1_reg  <= in_valid;
            valid_s2_reg  <= valid_s1_reg;
            out_valid_reg <= valid_s2_reg;
        end
    end

    assign out_valid = out_valid_reg;
    assign out       = {g_comp[0].comp_reg, g_comp[1].comp_reg, g_comp[2].comp_reg};

`ifdef YCC_PIX_CNT_EN
    logic [11:0] pix_cnt_reg;
    logic [11:0] pix_cnt_next;
    logic        blk_done_reg;

    // Count the beat currently on the output; pix_cnt_next is therefore the
    // pre-increment count that will be shown alongside the next beat.
    assign pix_cnt_next = pix_cnt_reg + {11'd0, out_valid_reg};

    always_ff @(posedge clock) begin
        if (reset) begin
            pix_cnt_reg  <= '0;
            blk_done_reg <= 1'b0;
        end else begin
            pix_cnt_reg  <= pix_cnt_next;
            // Registered one stage early so the pulse lines up with the beat.
            blk_done_reg <= valid_s2_reg && (pix_cnt_next[5:0] == 6'd63);
        end
    end

    assign pix_cnt  = pix_cnt_reg;
    assign blk_done = blk_done_reg;
`else
    // Core-only build: no beat counter or block pulse.
`endif

endmodule

// File: tb/tb_rgb_to_ycbcr.sv
module tb_rgb_to_ycbcr;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic        out_valid;
    logic [23:0] out;
`ifdef YCC_PIX_CNT_EN
    logic [11:0] pix_cnt;
    logic        blk_done;
`endif

    rgb_to_ycbcr dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .r         (r),
        .g         (g),
        .b         (b),
        .out_valid (out_valid),
        .out       (out)
`ifdef YCC_PIX_CNT_EN
        ,
        .pix_cnt   (pix_cnt),
        .blk_done  (blk_done)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int beats  = 0;

    // Expected output per applied cycle; the entry for the cycle now on the
    // output sits three places from the end after each push.
    logic        hist_v[$];
    logic [23:0] hist_d[$];

    typedef struct {
        logic        v;
        logic [7:0]  r, g, b;
        logic [23:0] exp;
    } vec_t;

    // ---- reference model: the conversion rules in plain integer arithmetic
    function automatic int floor_div256(int x);
        return (x >= 0) ? x / 256 : -((-x + 255) / 256);
    endfunction

    function automatic int sat8(int x);
        return (x < 0) ? 0 : ((x > 255) ? 255 : x);
    endfunction

    function automatic logic [23:0] ref_ycc(int rr, int gg, int bb);
        int y, cb, cr;
        y  = sat8(floor_div256(  77*rr + 150*gg +  29*bb + 128));
        cb = sat8(floor_div256( -43*rr -  85*gg + 128*bb + 128) + 128);
        cr = sat8(floor_div256( 128*rr - 107*gg -  21*bb + 128) + 128);
        return {y[7:0], cb[7:0], cr[7:0]};
    endfunction

    task automatic check_cycle();
        int          idx;
        logic        ev;
        logic [23:0] ed;
        idx = hist_v.size() - 3;
        ev  = hist_v[idx];
        ed  = hist_d[idx];
        checks++;
        if (out_valid !== ev) begin
            errors++;
            $display("FAIL out_valid cyc=%0d: got %b want %b", cyc, out_valid, ev);
        end
        if (ev) begin
            checks++;
            if (out !== ed) begin
                errors++;
                $display("FAIL out cyc=%0d: got %06h want %06h", cyc, out, ed);
            end
        end
`ifdef YCC_PIX_CNT_EN
        checks++;
        if (pix_cnt !== 12'(beats)) begin
            errors++;
            $display("FAIL pix_cnt cyc=%0d: got %0d want %0d", cyc, pix_cnt, beats % 4096);
        end
        if (ev) beats++;
        checks++;
        if (blk_done !== (ev && (beats % 64 == 0))) begin
            errors++;
            $display("FAIL blk_done cyc=%0d: got %b want %b (beat %0d)", cyc, blk_done,
                     ev && (beats % 64 == 0), beats);
        end
`endif
    endtask

    // Drive one cycle of input, then compare what is on the output after the edge.
    task automatic step(input logic v, input logic [7:0] rr, input logic [7:0] gg,
                        input logic [7:0] bb, input logic [23:0] exp);
        in_valid = v;
        r = rr;
        g = gg;
        b = bb;
        hist_v.push_back(v);
        hist_d.push_back(exp);
        @(posedge clock);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        checks++;
        if (out_valid !== 1'b0 || out !== 24'h0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b out=%06h want valid=0 out=000000", out_valid, out);
        end
`ifdef YCC_PIX_CNT_EN
        checks++;
        if (pix_cnt !== 12'd0 || blk_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt: got pix_cnt=%0d blk_done=%b want 0 0", pix_cnt, blk_done);
        end
`endif
        reset = 1'b0;
        hist_v.delete();
        hist_d.delete();
        // Two cleared stages sit ahead of the first post-reset pixel.
        repeat (2) begin
            hist_v.push_back(1'b0);
            hist_d.push_back(24'h0);
        end
        beats = 0;
    endtask

    task automatic flush();
        repeat (3) step(1'b0, 8'd0, 8'd0, 8'd0, 24'h0);
    endtask

    vec_t tbl [17];

    initial begin
        tbl = '{
            '{1'b1, 8'd0,   8'd0,   8'd0,   24'h008080},
            '{1'b0, 8'd0,   8'd0,   8'd0,   24'h000000},
            '{1'b1, 8'd255, 8'd255, 8'd255, 24'hFF8080},
            '{1'b0, 8'd0,   8'd0,   8'd0,   24'h000000},
            '{1'b1, 8'd255, 8'd0,   8'd0,   24'h4D55FF},
            '{1'b1, 8'd0,   8'd255, 8'd0,   24'h952B15},
            '{1'b1, 8'd0,   8'd0,   8'd255, 24'h1DFF6B},
            '{1'b0, 8'd0,   8'd0,   8'd0,   24'h000000},
            '{1'b1, 8'd255, 8'd0,   8'd0,   24'h4D55FF},
            '{1'b0, 8'd17,  8'd99,  8'd3,   24'h000000},
            '{1'b1, 8'd0,   8'd255, 8'd0,   24'h952B15},
            '{1'b1, 8'd0,   8'd0,   8'd255, 24'h1DFF6B},
            '{1'b0, 8'd200, 8'd1,   8'd90,  24'h000000},
            '{1'b1, 8'd128, 8'd128, 8'd128, 24'h808080},
            '{1'b1, 8'd10,  8'd200, 8'd50,  24'h7E552D},
            '{1'b0, 8'd0,   8'd0,   8'd0,   24'h000000},
            '{1'b0, 8'd0,   8'd0,   8'd0,   24'h000000}
        };

        do_reset(2);

        // Directed vectors: corners, primaries back-to-back, gapped pattern.
        for (int i = 0; i < 17; i++)
            step(tbl[i].v, tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].exp);
        flush();

        // Mid-stream reset: three pixels in flight are discarded.
        step(1'b1, 8'd255, 8'd0,   8'd0,   24'h4D55FF);
        step(1'b1, 8'd0,   8'd255, 8'd0,   24'h952B15);
        step(1'b1, 8'd0,   8'd0,   8'd255, 24'h1DFF6B);
        do_reset(1);
        step(1'b1, 8'd10, 8'd200, 8'd50, 24'h7E552D);
        flush();

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic       v;
            logic [7:0] rr, gg, bb;
            v = ($urandom_range(3) != 0);
            if ($urandom_range(3) == 0) begin
                rr = $urandom_range(1) ? 8'd255 : 8'd0;
                gg = $urandom_range(1) ? 8'd255 : 8'd0;
                bb = $urandom_range(1) ? 8'd255 : 8'd0;
            end else begin
                rr = 8'($urandom);
                gg = 8'($urandom);
                bb = 8'($urandom);
            end
            step(v, rr, gg, bb, ref_ycc(rr, gg, bb));
        end
        flush();

`ifdef YCC_PIX_CNT_EN
        // 130 beats: pulses on beats 64 and 128, count ends at 130.
        do_reset(1);
        for (int i = 0; i < 130; i++) begin
            logic [7:0] rr, gg, bb;
            rr = 8'($urandom);
            gg = 8'($urandom);
            bb = 8'($urandom);
            step(1'b1, rr, gg, bb, ref_ycc(rr, gg, bb));
        end
        flush();
        checks++;
        if (pix_cnt !== 12'd130) begin
            errors++;
            $display("FAIL pix_cnt_130: got %0d want 130", pix_cnt);
        end
        // Continue to 4096 beats total so the counter wraps to zero.
        for (int i = 130; i < 4096; i++) begin
            logic [7:0] rr, gg, bb;
            rr = 8'($urandom);
            gg = 8'($urandom);
            bb = 8'($urandom);
            step(1'b1, rr, gg, bb, ref_ycc(rr, gg, bb));
        end
        flush();
        checks++;
        if (pix_cnt !== 12'd0) begin
            errors++;
            $display("FAIL pix_cnt_wrap: got %0d want 0", pix_cnt);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
